// File: rtl/narrow_mem_link.sv
// narrow_mem_link: serialises core memory requests onto a LaneWidth-bit link and
// deserialises in-order read responses, tagging each with the id of its read.
// Revision 1.0 - initial release
`default_nettype none

module narrow_mem_link #(
    parameter int AddrWidth      = 8,
    parameter int DataWidth      = 32,
    parameter int LaneWidth      = 4,
    parameter int IdWidth        = 1,
    parameter int MaxOutstanding = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [AddrWidth-1:0]                  req_addr_i,
    input  logic [DataWidth-1:0]                  req_data_i,
    input  logic [DataWidth/8-1:0]                req_strb_i,
    input  logic                                  req_write_i,
    input  logic [IdWidth-1:0]                    req_id_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    output logic [DataWidth-1:0]                  rsp_data_o,
    output logic [IdWidth-1:0]                    rsp_id_o,
    output logic                                  rsp_error_o,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [AddrWidth-1:0]                  link_addr_o,
    output logic                                  link_write_o,
    output logic [LaneWidth-1:0]                  link_data_o,
    output logic                                  link_strb_o,
    output logic                                  link_valid_o,
    input  logic                                  link_ready_i,
    input  logic [LaneWidth-1:0]                  link_rsp_data_i,
    input  logic                                  link_rsp_last_i,
    input  logic                                  link_rsp_valid_i,
    output logic                                  link_rsp_ready_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);

    localparam int Beats = DataWidth / LaneWidth;
    localparam int CntW  = $clog2(Beats + 1);
    localparam int OccW  = $clog2(MaxOutstanding + 1);
    localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    if (((DataWidth % LaneWidth) != 0) ||
        !((LaneWidth == 1) || (LaneWidth == 2) || (LaneWidth == 4) || (LaneWidth == 8)))
    begin : g_bad_params
        $error("narrow_mem_link: LaneWidth must be 1/2/4/8 and divide DataWidth");
    end

    typedef enum logic [0:0] {REQ_IDLE = 1'b0, REQ_SEND = 1'b1} req_state_t;
    typedef enum logic [0:0] {RSP_COLLECT = 1'b0, RSP_HOLD = 1'b1} rsp_state_t;

    req_state_t             req_state_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth-1:0]   data_q;
    logic [Beats-1:0]       beat_strb_q;
    logic                   write_q;
    logic [CntW-1:0]        beat_q;

    rsp_state_t             rsp_state_q;
    logic [DataWidth-1:0]   acc_q;
    logic [CntW-1:0]        rcnt_q;
    logic                   err_q;

    logic [IdWidth-1:0]     fifo_mem [MaxOutstanding];
    logic [PtrW-1:0]        wr_ptr_q;
    logic [PtrW-1:0]        rd_ptr_q;
    logic [OccW-1:0]        count_q;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   req_accept;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [Beats-1:0]       beat_strb;
    logic [CntW:0]          rcnt_inc;

    // Byte strobes are expanded to one bit per beat at accept time so the
    // send path only ever shifts, never indexes.
    for (genvar b = 0; b < Beats; b++) begin : g_beat_strb
        assign beat_strb[b] = req_strb_i[(b * LaneWidth) / 8];
    end

    assign fifo_full   = (count_q == OccW'(MaxOutstanding));
    assign fifo_empty  = (count_q == '0);
    assign req_ready_o = ~rst_i & (req_state_q == REQ_IDLE) & (req_write_i | ~fifo_full);
    assign req_accept  = req_valid_i & req_ready_o;
    assign fifo_push   = req_accept & ~req_write_i;
    assign fifo_pop    = (rsp_state_q == RSP_HOLD) & rsp_ready_i & ~fifo_empty;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_state_q <= REQ_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            beat_strb_q <= '0;
            write_q     <= 1'b0;
            beat_q      <= '0;
        end else begin
            case (req_state_q)
                REQ_IDLE: begin
                    if (req_accept) begin
                        addr_q      <= req_addr_i;
                        data_q      <= req_data_i;
                        beat_strb_q <= beat_strb;
                        write_q     <= req_write_i;
                        beat_q      <= '0;
                        req_state_q <= REQ_SEND;
                    end
                end
                REQ_SEND: begin
                    if (link_ready_i) begin
                        if (write_q) begin
                            data_q      <= data_q >> LaneWidth;
                            beat_strb_q <= beat_strb_q >> 1;
                            beat_q      <= beat_q + CntW'(1);
                            if (beat_q == CntW'(Beats - 1)) begin
                                req_state_q <= REQ_IDLE;
                            end
                        end else begin
                            req_state_q <= REQ_IDLE;
                        end
                    end
                end
                default: req_state_q <= REQ_IDLE;
            endcase
        end
    end

    assign link_valid_o = (req_state_q == REQ_SEND);
    assign link_addr_o  = addr_q;
    assign link_write_o = write_q;
    assign link_data_o  = (link_valid_o && write_q) ? data_q[LaneWidth-1:0] : '0;
    assign link_strb_o  = link_valid_o & write_q & beat_strb_q[0];

    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= req_id_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (fifo_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (fifo_push && !fifo_pop) begin
                count_q <= count_q + OccW'(1);
            end else if (!fifo_push && fifo_pop) begin
                count_q <= count_q - OccW'(1);
            end
        end
    end

    assign outstanding_o = count_q;
    assign rcnt_inc      = {1'b0, rcnt_q} + (CntW + 1)'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_state_q <= RSP_COLLECT;
            acc_q       <= '0;
            rcnt_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            case (rsp_state_q)
                RSP_COLLECT: begin
                    if (link_rsp_valid_i) begin
                        acc_q <= {acc_q[DataWidth-LaneWidth-1:0], link_rsp_data_i};
                        // A beat past a full word is an overrun: oldest data falls off.
                        if (rcnt_q != CntW'(Beats)) begin
                            rcnt_q <= rcnt_q + CntW'(1);
                        end else begin
                            err_q <= 1'b1;
                        end
                        if (link_rsp_last_i) begin
                            err_q       <= err_q | (rcnt_inc != (CntW + 1)'(Beats)) | fifo_empty;
                            rsp_state_q <= RSP_HOLD;
                        end
                    end
                end
                RSP_HOLD: begin
                    if (rsp_ready_i) begin
                        acc_q       <= '0;
                        rcnt_q      <= '0;
                        err_q       <= 1'b0;
                        rsp_state_q <= RSP_COLLECT;
                    end
                end
                default: rsp_state_q <= RSP_COLLECT;
            endcase
        end
    end

    assign link_rsp_ready_o = ~rst_i & (rsp_state_q == RSP_COLLECT);
    assign rsp_valid_o      = (rsp_state_q == RSP_HOLD);
    assign rsp_data_o       = rsp_valid_o ? acc_q : '0;
    assign rsp_error_o      = rsp_valid_o & err_q;
    assign rsp_id_o         = (rsp_valid_o && !fifo_empty) ? fifo_mem[rd_ptr_q] : '0;

endmodule

`default_nettype wire

// File: tb/tb_narrow_mem_link.sv
// tb_narrow_mem_link: directed self-checking bench for narrow_mem_link.
// Revision 1.0 - initial release
`default_nettype none

module tb_narrow_mem_link;

    logic        clk;
    logic        rst;
    logic [7:0]  req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_strb;
    logic        req_write;
    logic [0:0]  req_id;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] rsp_data;
    logic [0:0]  rsp_id;
    logic        rsp_error;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  link_addr;
    logic        link_write;
    logic [3:0]  link_data;
    logic        link_strb;
    logic        link_valid;
    logic        link_ready;
    logic [3:0]  link_rsp_data;
    logic        link_rsp_last;
    logic        link_rsp_valid;
    logic        link_rsp_ready;
    logic [1:0]  outstanding;

    int n_checks = 0;
    int n_fail   = 0;

    narrow_mem_link #(
        .AddrWidth      (8),
        .DataWidth      (32),
        .LaneWidth      (4),
        .IdWidth        (1),
        .MaxOutstanding (2)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_addr_i       (req_addr),
        .req_data_i       (req_data),
        .req_strb_i       (req_strb),
        .req_write_i      (req_write),
        .req_id_i         (req_id),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .rsp_data_o       (rsp_data),
        .rsp_id_o         (rsp_id),
        .rsp_error_o      (rsp_error),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .link_addr_o      (link_addr),
        .link_write_o     (link_write),
        .link_data_o      (link_data),
        .link_strb_o      (link_strb),
        .link_valid_o     (link_valid),
        .link_ready_i     (link_ready),
        .link_rsp_data_i  (link_rsp_data),
        .link_rsp_last_i  (link_rsp_last),
        .link_rsp_valid_i (link_rsp_valid),
        .link_rsp_ready_o (link_rsp_ready),
        .outstanding_o    (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {link_valid, link_data, link_strb, link_addr, link_write, req_ready,
                    rsp_valid, rsp_data, rsp_id, rsp_error, link_rsp_ready, outstanding}, 64'h0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        req_addr   = a;
        req_data   = d;
        req_strb   = s;
        req_write  = 1'b1;
        req_valid  = 1'b1;
        link_ready = 1'b1;
        #1;
        check("wr_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("wr_valid", link_valid, 1);
            check("wr_data", link_data, d[i*4 +: 4]);
            check("wr_strb", link_strb, s[i/2]);
            check("wr_addr", link_addr, a);
            check("wr_write", link_write, 1);
            check("wr_outstanding", outstanding, 0);
            tick();
        end
        check("wr_done_idle", link_valid, 0);
        check("wr_ready_back", req_ready, 1);
    endtask

    task automatic do_read(input logic [0:0] id, input logic [7:0] a);
        req_addr   = a;
        req_id     = id;
        req_write  = 1'b0;
        req_valid  = 1'b1;
        link_ready = 1'b1;
        #1;
        check("rd_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        #1;
        check("rd_valid", link_valid, 1);
        check("rd_write", link_write, 0);
        check("rd_data", link_data, 0);
        check("rd_strb", link_strb, 0);
        check("rd_addr", link_addr, a);
        tick();
        check("rd_done_idle", link_valid, 0);
    endtask

    // Sends the low n nibbles of w, most significant first, last on the final one.
    task automatic send_frame(input logic [31:0] w, input int n);
        check("frame_rsp_ready", link_rsp_ready, 1);
        for (int k = 0; k < n; k++) begin
            link_rsp_valid = 1'b1;
            link_rsp_data  = w[(n-1-k)*4 +: 4];
            link_rsp_last  = (k == n - 1);
            tick();
        end
        link_rsp_valid = 1'b0;
        link_rsp_last  = 1'b0;
        link_rsp_data  = 4'h0;
    endtask

    task automatic pop_rsp(input logic [31:0] d, input logic [0:0] id, input logic err);
        #1;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, d);
        check("rsp_id", rsp_id, id);
        check("rsp_error", rsp_error, err);
        check("rsp_hold_link_ready", link_rsp_ready, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check("rsp_released", rsp_valid, 0);
    endtask

    initial begin
        int         acc;
        int         cyc;
        logic [3:0] pat;
        logic [31:0] sd;
        logic [3:0]  ss;

        rst = 1'b1;
        req_addr = '0; req_data = '0; req_strb = '0; req_write = 1'b0;
        req_id = '0; req_valid = 1'b0; rsp_ready = 1'b0; link_ready = 1'b0;
        link_rsp_data = '0; link_rsp_last = 1'b0; link_rsp_valid = 1'b0;
        tick();
        tick();
        check_all_zero("reset_outputs");
        rst = 1'b0;
        #1;

        // 1: plain write
        do_write(8'h3C, 32'hDEADBEEF, 4'b0101);

        // 2: single read and its response
        do_read(1'b1, 8'h10);
        check("rd_outstanding_1", outstanding, 1);
        send_frame(32'h12345678, 8);
        pop_rsp(32'h12345678, 1'b1, 1'b0);
        check("rd_outstanding_0", outstanding, 0);

        // 3: write with link backpressure 1,0,0,1 repeating
        sd  = 32'h87654321;
        ss  = 4'b1010;
        pat = 4'b1001;
        req_addr = 8'h55; req_data = sd; req_strb = ss; req_write = 1'b1; req_valid = 1'b1;
        link_ready = 1'b1;
        #1;
        check("stall_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < 8 && cyc < 40) begin
            link_ready = pat[cyc % 4];
            #1;
            check("stall_valid", link_valid, 1);
            check("stall_data", link_data, sd[acc*4 +: 4]);
            check("stall_strb", link_strb, ss[acc/2]);
            if (link_ready) acc++;
            cyc++;
            tick();
        end
        check("stall_beats", acc, 8);
        check("stall_done_idle", link_valid, 0);
        link_ready = 1'b1;

        // 4: three reads against a two-deep id FIFO
        req_write = 1'b0; req_valid = 1'b1; req_id = 1'b0; req_addr = 8'h20;
        #1;
        check("q_ready_a", req_ready, 1);
        tick();
        req_id = 1'b1; req_addr = 8'h21;
        tick();
        check("q_ready_b", req_ready, 1);
        tick();
        check("q_outstanding_2", outstanding, 2);
        req_id = 1'b0; req_addr = 8'h22;
        tick();
        check("q_full_block", req_ready, 0);
        tick();
        check("q_full_block_2", req_ready, 0);
        send_frame(32'h11111111, 8);
        check("q_block_during_rsp", req_ready, 0);
        #1;
        check("q_first_id", rsp_id, 0);
        check("q_first_data", rsp_data, 32'h11111111);
        rsp_ready = 1'b1;
        #1;
        check("q_no_bypass", req_ready, 0);
        tick();
        rsp_ready = 1'b0;
        #1;
        check("q_ready_after_pop", req_ready, 1);
        check("q_outstanding_after_pop", outstanding, 1);
        tick();
        req_valid = 1'b0;
        check("q_outstanding_refill", outstanding, 2);
        tick();
        send_frame(32'h22222222, 8);
        pop_rsp(32'h22222222, 1'b1, 1'b0);
        send_frame(32'h33333333, 8);
        pop_rsp(32'h33333333, 1'b0, 1'b0);
        check("q_outstanding_drained", outstanding, 0);

        // 5: short frame, then an unsolicited frame
        do_read(1'b1, 8'h30);
        send_frame(32'h00000ABC, 3);
        pop_rsp(32'h00000ABC, 1'b1, 1'b1);
        check("short_outstanding", outstanding, 0);
        send_frame(32'h55AA55AA, 8);
        pop_rsp(32'h55AA55AA, 1'b0, 1'b1);

        // 6: reset in the middle of a write with a read outstanding
        do_read(1'b0, 8'h40);
        check("rst_pre_outstanding", outstanding, 1);
        sd = 32'hCAFEF00D;
        req_addr = 8'h77; req_data = sd; req_strb = 4'hF; req_write = 1'b1; req_valid = 1'b1;
        link_ready = 1'b1;
        #1;
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_pre_data", link_data, sd[i*4 +: 4]);
            tick();
        end
        rst = 1'b1;
        #1;
        check_all_zero("rst_async_outputs");
        tick();
        check_all_zero("rst_next_cycle_outputs");
        rst = 1'b0;
        #1;
        check("rst_post_outstanding", outstanding, 0);
        do_write(8'h5A, 32'h13579BDF, 4'b0011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
